// File: rtl/instruction_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
//   imm_fmt_e     : immediate/packing format selector (3 bits)
//   enc_fields_t  : decoded instruction fields carried through stage 1
//   NOP_INSTR     : word emitted in place of an entry with an illegal immediate
//   IMM_*_MIN/MAX : legal signed immediate ranges per format
package instruction_encoder_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FMT_W      = 3;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned F3_W       = 3;
    localparam int unsigned F7_W       = 7;

    typedef enum logic [FMT_W-1:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_S_MIN = -2048;
    localparam int IMM_S_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        imm_fmt_e              fmt;
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_W-1:0]      rd;
        logic [REG_W-1:0]      rs1;
        logic [REG_W-1:0]      rs2;
        logic [F3_W-1:0]       funct3;
        logic [F7_W-1:0]       funct7;
        logic [DATA_WIDTH-1:0] imm;
    } enc_fields_t;

    // Signed inclusive range test of a full-width immediate.
    function automatic logic imm_in_range(input logic [DATA_WIDTH-1:0] imm,
                                          input int lo, input int hi);
        int v;
        v = int'($signed(imm));
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instruction_encoder_imm_packer.sv
// imm_packer: combinational immediate legality check and instruction packing.
//   i_fields : decoded fields (format, opcode, registers, functs, immediate)
//   o_instr  : packed 32-bit word, or NOP_INSTR when the immediate is illegal
//   o_imm_ok : immediate is legal for the selected format
module imm_packer
    import instruction_encoder_pkg::*;
(
    input  enc_fields_t                i_fields,
    output logic [DATA_WIDTH-1:0]      o_instr,
    output logic                       o_imm_ok
);

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_ok;

    // Per-format legality and bit scattering; unknown formats are illegal.
    always_comb begin
        w_word = '0;
        w_ok   = 1'b0;
        case (i_fields.fmt)
            FMT_R: begin
                w_ok   = 1'b1;
                w_word = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                          i_fields.funct3, i_fields.rd, i_fields.opcode};
            end
            FMT_I: begin
                w_ok   = imm_in_range(i_fields.imm, IMM_I_MIN, IMM_I_MAX);
                w_word = {i_fields.imm[11:0], i_fields.rs1, i_fields.funct3,
                          i_fields.rd, i_fields.opcode};
            end
            FMT_S: begin
                w_ok   = imm_in_range(i_fields.imm, IMM_S_MIN, IMM_S_MAX);
                w_word = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                          i_fields.funct3, i_fields.imm[4:0], i_fields.opcode};
            end
            FMT_B: begin
                w_ok   = imm_in_range(i_fields.imm, IMM_B_MIN, IMM_B_MAX)
                         && !i_fields.imm[0];
                w_word = {i_fields.imm[12], i_fields.imm[10:5], i_fields.rs2,
                          i_fields.rs1, i_fields.funct3, i_fields.imm[4:1],
                          i_fields.imm[11], i_fields.opcode};
            end
            FMT_U: begin
                w_ok   = (i_fields.imm[11:0] == 12'h000);
                w_word = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
            end
            FMT_J: begin
                w_ok   = imm_in_range(i_fields.imm, IMM_J_MIN, IMM_J_MAX)
                         && !i_fields.imm[0];
                w_word = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                          i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
            end
            default: begin
                w_ok   = 1'b0;
                w_word = '0;
            end
        endcase
        o_imm_ok = w_ok;
        o_instr  = w_ok ? w_word : NOP_INSTR;
    end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: two-stage streaming RV32I encoder feeding an
// instruction-memory write port with an auto-incrementing word address.
//   clk_i, rst_i (sync, active-high), clear_i (sync flush)
//   in_valid_i/in_ready_o + fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
//       funct3_i, funct7_i, imm_i : decoded field input
//   out_valid_o/out_ready_i + instr_o, addr_o, err_o : write-port output
//   err_sticky_o : latched on any errored output handshake
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [FMT_W-1:0]      fmt_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    input  logic [REG_W-1:0]      rd_i,
    input  logic [REG_W-1:0]      rs1_i,
    input  logic [REG_W-1:0]      rs2_i,
    input  logic [F3_W-1:0]       funct3_i,
    input  logic [F7_W-1:0]       funct7_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  err_o,
    output logic                  err_sticky_o
);

    logic                  r_s1_valid;
    enc_fields_t           r_s1_fields;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_err;
    logic                  r_sticky;
    logic [ADDR_WIDTH-1:0] r_addr;

    enc_fields_t           w_in_fields;
    logic [DATA_WIDTH-1:0] w_packed;
    logic                  w_imm_ok;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_s2_free;
    logic                  w_s1_adv;

    // Gather the input fields into the stage-1 payload.
    always_comb begin
        w_in_fields        = '0;
        w_in_fields.fmt    = imm_fmt_e'(fmt_i);
        w_in_fields.opcode = opcode_i;
        w_in_fields.rd     = rd_i;
        w_in_fields.rs1    = rs1_i;
        w_in_fields.rs2    = rs2_i;
        w_in_fields.funct3 = funct3_i;
        w_in_fields.funct7 = funct7_i;
        w_in_fields.imm    = imm_i;
    end

    // Handshake terms; clear blocks both the input and the output handshake.
    assign in_ready_o = !clear_i && (!r_s1_valid || !r_s2_valid || out_ready_i);
    assign w_in_hs    = in_valid_i && in_ready_o;
    assign w_out_hs   = r_s2_valid && out_ready_i && !clear_i;
    assign w_s2_free  = !r_s2_valid || out_ready_i;
    assign w_s1_adv   = r_s1_valid && w_s2_free;

    imm_packer u_imm_packer (
        .i_fields (r_s1_fields),
        .o_instr  (w_packed),
        .o_imm_ok (w_imm_ok)
    );

    // Pipeline registers, address counter and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_fields <= '0;
            r_s2_valid  <= 1'b0;
            r_instr     <= '0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_addr      <= BASE_ADDR;
        end else if (clear_i) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_sticky    <= 1'b0;
            r_addr      <= BASE_ADDR;
        end else begin
            // Stage 2 loads whenever stage 1 can move; otherwise it drains.
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_instr    <= w_packed;
                r_err      <= !w_imm_ok;
            end else if (w_out_hs) begin
                r_s2_valid <= 1'b0;
            end

            if (w_in_hs) begin
                r_s1_valid  <= 1'b1;
                r_s1_fields <= w_in_fields;
            end else if (w_s1_adv) begin
                r_s1_valid  <= 1'b0;
            end

            // Errored words still consume an address to keep the layout intact.
            if (w_out_hs) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                if (r_err) begin
                    r_sticky <= 1'b1;
                end
            end
        end
    end

    assign out_valid_o  = r_s2_valid;
    assign instr_o      = r_instr;
    assign addr_o       = r_addr;
    assign err_o        = r_err;
    assign err_sticky_o = r_sticky;

endmodule
